// File: rtl/banco8_registros16_bit.sv
// Eight-entry, 16-bit register file.
// One synchronous write port, two combinational read ports.
module banco8_registros16_bit (
    output logic [15:0] RtaA,
    output logic [15:0] RtaB,
    input  logic [15:0] Tupla,
    input  logic        Reloj,
    input  logic        Reiniciar,
    input  logic        Habilitar,
    input  logic [2:0]  DireccionEscritura,
    input  logic [2:0]  DireccionA,
    input  logic [2:0]  DireccionB
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    // Next state: hold everything, load the addressed entry when enabled
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (Habilitar) begin
            regs_d[DireccionEscritura] = Tupla;
        end
    end

    // Storage update; reset wins over any pending write
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports see stored state only, no write-through
    assign RtaA = regs_q[DireccionA];
    assign RtaB = regs_q[DireccionB];

endmodule

// File: tb/tb_banco8_registros16_bit.sv
// Bench for banco8_registros16_bit.
// Expected read data is queued at address drive and popped at sample.
module tb_banco8_registros16_bit;

    logic [15:0] RtaA;
    logic [15:0] RtaB;
    logic [15:0] Tupla;
    logic        Reloj;
    logic        Reiniciar;
    logic        Habilitar;
    logic [2:0]  DireccionEscritura;
    logic [2:0]  DireccionA;
    logic [2:0]  DireccionB;

    logic [15:0] model [8];
    logic [15:0] exp_q [$];
    int          checks;
    int          errors;

    banco8_registros16_bit dut (
        .RtaA               (RtaA),
        .RtaB               (RtaB),
        .Tupla              (Tupla),
        .Reloj              (Reloj),
        .Reiniciar          (Reiniciar),
        .Habilitar          (Habilitar),
        .DireccionEscritura (DireccionEscritura),
        .DireccionA         (DireccionA),
        .DireccionB         (DireccionB)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive both read addresses, queue expectations, then compare
    task automatic read_pair(input string tag, input logic [2:0] a,
                             input logic [2:0] b);
        logic [15:0] ea;
        logic [15:0] eb;
        DireccionA = a;
        DireccionB = b;
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check($sformatf("%s_A%0d", tag, a), RtaA, ea);
        check($sformatf("%s_B%0d", tag, b), RtaB, eb);
    endtask

    // Wait for the next rising edge and apply the reference behaviour
    task automatic clk_edge();
        @(posedge Reloj);
        if (Reiniciar) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else if (Habilitar) begin
            model[DireccionEscritura] = Tupla;
        end
        #1;
    endtask

    task automatic do_write(input logic [2:0] wa, input logic [15:0] d);
        @(negedge Reloj);
        Habilitar          = 1'b1;
        DireccionEscritura = wa;
        Tupla              = d;
        clk_edge();
        Habilitar = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
        Tupla              = 16'h0000;
        Reiniciar          = 1'b1;
        Habilitar          = 1'b0;
        DireccionEscritura = 3'd0;
        DireccionA         = 3'd0;
        DireccionB         = 3'd0;

        // Reset then sweep every address on both ports
        @(negedge Reloj);
        clk_edge();
        Reiniciar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_pair("rst_sweep", 3'(i), 3'(7 - i));
        end

        // Write 3 to R7; old value before the edge, new after
        @(negedge Reloj);
        Habilitar          = 1'b1;
        DireccionEscritura = 3'd7;
        Tupla              = 16'h0003;
        read_pair("r7_pre", 3'd7, 3'd7);
        check("r7_pre_lit", RtaA, 16'h0000);
        clk_edge();
        Habilitar = 1'b0;
        read_pair("r7_post", 3'd7, 3'd7);
        check("r7_post_lit", RtaA, 16'h0003);

        // Write 5 to R4; R7 unaffected
        do_write(3'd4, 16'h0005);
        read_pair("r4_r7", 3'd7, 3'd4);
        check("r7_keep_lit", RtaA, 16'h0003);
        check("r4_lit", RtaB, 16'h0005);

        // Reset with enable asserted; no effect until the edge
        @(negedge Reloj);
        Reiniciar          = 1'b1;
        Habilitar          = 1'b1;
        DireccionEscritura = 3'd4;
        Tupla              = 16'h0009;
        read_pair("rst_pre", 3'd7, 3'd4);
        clk_edge();
        Reiniciar = 1'b0;
        Habilitar = 1'b0;
        read_pair("rst_wr", 3'd7, 3'd4);
        check("rst_r4_lit", RtaB, 16'h0000);

        // Disabled edges with changing data must hold R4
        do_write(3'd4, 16'h0005);
        DireccionB = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge Reloj);
            DireccionEscritura = 3'd4;
            Tupla              = 16'h000C + 16'(k);
            clk_edge();
            read_pair($sformatf("hold%0d", k), 3'd4, 3'd4);
            check($sformatf("hold_lit%0d", k), RtaB, 16'h0005);
        end

        // Distinct value per register, all-ones in R0, full pair sweep
        for (int i = 1; i < 8; i++) begin
            do_write(3'(i), 16'hA000 + 16'(i));
        end
        do_write(3'd0, 16'hFFFF);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                read_pair("pairs", 3'(a), 3'(b));
            end
        end
        read_pair("r0_ones", 3'd0, 3'd0);
        check("r0_ones_lit", RtaA, 16'hFFFF);
        read_pair("r5_lit", 3'd5, 3'd2);
        check("r5_lit_a", RtaA, 16'hA005);
        check("r2_lit_b", RtaB, 16'hA002);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
